ln_taylor_engine: RTL

- Self-sequenced fixed-point natural-log engine: ln(x) for signed Q(W-F).F input by range reduction plus an N-term alternating Taylor series.
- Range reduction normalises x to m in [0.75,1.5) with x = m*2^k. The series evaluates ln(1+u), where u = m-1 and |u| < 0.5. The result is corrected by k*ln2.
- Replaces the externally sequenced datapath/scaler/alu trio with one parametrised block: internal FSM, start/ready/valid handshake, error flag and saturation.

---
 rtl/ln_taylor_pkg.sv | 28 ++
 rtl/fx_mult_q.sv | 20 ++
 rtl/ln_taylor_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ln_taylor_pkg.sv
// Shared types and constant helpers for the fixed-point natural-log engine.
package ln_taylor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        POW,
        TERM,
        CORR,
        DONE
    } state_t;

    // Signed exponent width: enough for +/-W shifts plus a sign bit.
    function automatic int k_width(input int w);
        return $clog2(w) + 2;
    endfunction

    // round(2^f / n) for the series reciprocal table.
    function automatic longint recip_q(input int n, input int f);
        return ((longint'(1) << f) + longint'(n / 2)) / longint'(n);
    endfunction

    // round(ln2 * 2^f), derived from ln2 held in Q0.32.
    function automatic longint ln2_q(input int f);
        return (64'sd2977044472 + (64'sd1 << (31 - f))) >>> (32 - f);
    endfunction

endpackage

// File: rtl/fx_mult_q.sv
// Signed W x W fixed-point multiplier: full product plus the Q-aligned,
// W-bit truncated result (arithmetic shift by F, rounding toward -inf).
module fx_mult_q #(
    parameter int W = 16,
    parameter int F = 12
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   q_o,
    output logic [2*W-1:0] full_o
);

    logic signed [2*W-1:0] prod;

    assign prod   = $signed(a_i) * $signed(b_i);
    // Taking bits [F+W-1:F] equals (prod >>> F) truncated to W bits.
    assign q_o    = prod[F+W-1:F];
    assign full_o = prod;

endmodule

// File: rtl/ln_taylor_engine.sv
// Self-sequenced ln(x) engine: range-reduce x to m*2^k with m in [0.75,1.5),
// sum an N-term alternating series for ln(1+u), then add k*ln2 and saturate.
module ln_taylor_engine
    import ln_taylor_pkg::*;
#(
    parameter int W        = 16,
    parameter int F        = 12,
    parameter int MAX_ITER = 7,
    parameter int GUARD    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [W-1:0]                  x_i,
    input  logic [$clog2(MAX_ITER+1)-1:0] num_it_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [W-1:0]                  y_o,
    output logic                          err_o
);

    localparam int NW = $clog2(MAX_ITER + 1);
    localparam int KW = k_width(W);
    localparam int AW = W + GUARD;
    localparam int PW = 2 * W;

    localparam logic [W-1:0] ONE_Q = W'(1 << F);
    localparam logic [W-1:0] M_HI  = W'(3 << (F - 1));
    localparam logic [W-1:0] M_LO  = W'(3 << (F - 2));
    localparam logic [W-1:0] LN2_W = W'(ln2_q(F));

    // Entry 0 is unused padding so the table is indexed directly by n.
    function automatic logic [(MAX_ITER+1)*W-1:0] build_recip();
        logic [(MAX_ITER+1)*W-1:0] tab;
        tab = '0;
        for (int i = 1; i <= MAX_ITER; i++) begin
            tab[i*W +: W] = W'(recip_q(i, F));
        end
        return tab;
    endfunction

    localparam logic [(MAX_ITER+1)*W-1:0] RECIP_TAB = build_recip();

    state_t         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic [KW-1:0]  k_q, k_d;
    logic [NW-1:0]  n_q, n_d;
    logic [NW-1:0]  nmax_q, nmax_d;
    logic [W-1:0]   p_q, p_d;
    logic [W-1:0]   u_q, u_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [W-1:0]   y_q, y_d;
    logic           err_q, err_d;

    logic           x_nonpos;
    logic           m_hi;
    logic           m_lo;
    logic [NW-1:0]  n_clamp;
    logic [W-1:0]   recip_val;
    logic [W-1:0]   mul_a, mul_b;
    logic [W-1:0]   mul_q;
    logic [PW-1:0]  mul_full;
    logic [AW-1:0]  t_ext;
    logic [PW-1:0]  acc_ext;
    logic [PW-1:0]  r_sum;
    logic [W-1:0]   r_sat;

    assign x_nonpos  = x_i[W-1] | (x_i == '0);
    assign m_hi      = (m_q >= M_HI);
    assign m_lo      = (m_q < M_LO);
    assign recip_val = RECIP_TAB[int'(n_q)*W +: W];
    assign t_ext     = {{GUARD{mul_q[W-1]}}, mul_q};
    assign acc_ext   = {{(PW-AW){acc_q[AW-1]}}, acc_q};
    assign r_sum     = acc_ext + mul_full;

    // Clamp the requested term count into 1..MAX_ITER.
    always_comb begin
        n_clamp = num_it_i;
        if (num_it_i == '0) begin
            n_clamp = NW'(1);
        end else if (int'(num_it_i) > MAX_ITER) begin
            n_clamp = NW'(MAX_ITER);
        end
    end

    // Saturate the corrected sum into the W-bit signed range.
    always_comb begin
        r_sat = r_sum[W-1:0];
        if (r_sum[PW-1:W-1] != {(PW-W+1){r_sum[PW-1]}}) begin
            r_sat = r_sum[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Single shared multiplier: operands selected by the current state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            POW: begin
                mul_a = p_q;
                mul_b = u_q;
            end
            TERM: begin
                mul_a = p_q;
                mul_b = recip_val;
            end
            CORR: begin
                mul_a = {{(W-KW){k_q[KW-1]}}, k_q};
                mul_b = LN2_W;
            end
            default: ;
        endcase
    end

    fx_mult_q #(
        .W (W),
        .F (F)
    ) u_mult (
        .a_i    (mul_a),
        .b_i    (mul_b),
        .q_o    (mul_q),
        .full_o (mul_full)
    );

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            nmax_q  <= '0;
            p_q     <= '0;
            u_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            n_q     <= n_d;
            nmax_q  <= nmax_d;
            p_q     <= p_d;
            u_q     <= u_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = x_nonpos ? DONE : NORM;
            NORM: if (!m_hi && !m_lo) state_d = POW;
            POW:  state_d = TERM;
            TERM: state_d = (n_q == nmax_q) ? CORR : POW;
            CORR: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates for each state.
    always_comb begin
        m_d    = m_q;
        k_d    = k_q;
        n_d    = n_q;
        nmax_d = nmax_q;
        p_d    = p_q;
        u_d    = u_q;
        acc_d  = acc_q;
        y_d    = y_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (x_nonpos) begin
                        y_d   = '0;
                        err_d = 1'b1;
                    end else begin
                        m_d    = x_i;
                        k_d    = '0;
                        nmax_d = n_clamp;
                    end
                end
            end
            NORM: begin
                if (m_hi) begin
                    m_d = m_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (m_lo) begin
                    // m < 0.75 here, so doubling stays below 1.5.
                    m_d = m_q << 1;
                    k_d = k_q - 1'b1;
                end else begin
                    u_d   = m_q - ONE_Q;
                    p_d   = ONE_Q;
                    n_d   = NW'(1);
                    acc_d = '0;
                end
            end
            POW: begin
                p_d = mul_q;
            end
            TERM: begin
                // Odd terms add, even terms subtract: ln(1+u) = u - u^2/2 + ...
                acc_d = n_q[0] ? (acc_q + t_ext) : (acc_q - t_ext);
                if (n_q != nmax_q) begin
                    n_d = n_q + 1'b1;
                end
            end
            CORR: begin
                y_d   = r_sat;
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Handshake and result outputs.
    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        y_o     = y_q;
        err_o   = err_q;
    end

endmodule
